fetch_controller: RTL

- Instruction-fetch sequencer that sits between the program counter register and instruction memory.
- Reads the current PC and issues a valid/ready request to instruction memory.
- Waits a variable number of cycles for the response, then presents the instruction and its PC to the IF/ID stage.
- Drives the PC's Address/PCWrite inputs: sequential advance, stall hold, or branch/jump redirect with squash of in-flight fetches.

---
 rtl/fetch_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: issues one request at a time to instruction memory,
// presents the returned word to IF/ID and steers the PC (advance, hold, redirect).
module fetch_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PC_INCR    = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] PCResult,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  PCWrite,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] RedirectTarget,
    input  logic                  Stall,
    output logic                  MemReqValid,
    output logic [ADDR_WIDTH-1:0] MemReqAddr,
    input  logic                  MemReqReady,
    input  logic                  MemRespValid,
    input  logic [DATA_WIDTH-1:0] MemRespData,
    output logic                  InstrValid,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [ADDR_WIDTH-1:0] InstrPC
);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INCR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic                  kill_reg, kill_next;
    logic [ADDR_WIDTH-1:0] req_addr_reg, req_addr_next;
    logic                  instr_valid_reg, instr_valid_next;
    logic [DATA_WIDTH-1:0] instr_reg, instr_next;
    logic [ADDR_WIDTH-1:0] instr_pc_reg, instr_pc_next;
    logic [ADDR_WIDTH-1:0] seq_pc;

    assign seq_pc = PCResult + PC_STEP;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg       <= IDLE;
            kill_reg        <= 1'b0;
            req_addr_reg    <= '0;
            instr_valid_reg <= 1'b0;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            kill_reg        <= kill_next;
            req_addr_reg    <= req_addr_next;
            instr_valid_reg <= instr_valid_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        kill_next        = kill_reg;
        req_addr_next    = req_addr_reg;
        instr_valid_next = instr_valid_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        case (state_reg)
            IDLE: begin
                req_addr_next = Redirect ? RedirectTarget : PCResult;
                state_next    = REQ;
            end
            REQ: begin
                // The request cannot be withdrawn, so a redirect marks it for discard instead.
                if (Redirect) begin
                    kill_next = 1'b1;
                end
                if (MemReqReady) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (MemRespValid) begin
                    if (Redirect || kill_reg) begin
                        kill_next     = 1'b0;
                        req_addr_next = Redirect ? RedirectTarget : PCResult;
                        state_next    = REQ;
                    end else begin
                        instr_next       = MemRespData;
                        instr_pc_next    = req_addr_reg;
                        instr_valid_next = 1'b1;
                        state_next       = VALID;
                    end
                end else if (Redirect) begin
                    kill_next = 1'b1;
                end
            end
            VALID: begin
                if (Redirect) begin
                    instr_valid_next = 1'b0;
                    req_addr_next    = RedirectTarget;
                    state_next       = REQ;
                end else if (!Stall) begin
                    instr_valid_next = 1'b0;
                    req_addr_next    = seq_pc;
                    state_next       = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC steering is combinational; reset forces it quiet regardless of the other inputs.
    always_comb begin
        PCWrite = 1'b0;
        Address = PCResult;
        if (!Reset_n) begin
            Address = '0;
        end else if (Redirect) begin
            PCWrite = 1'b1;
            Address = RedirectTarget;
        end else if (state_reg == VALID && !Stall) begin
            PCWrite = 1'b1;
            Address = seq_pc;
        end
    end

    assign MemReqValid = (state_reg == REQ);
    assign MemReqAddr  = req_addr_reg;
    assign InstrValid  = instr_valid_reg;
    assign Instr       = instr_reg;
    assign InstrPC     = instr_pc_reg;

endmodule
